// File: rtl/sync_fifo_flagged_if.sv
// Bundle of the FIFO's write, read and status signals.
// The master side drives requests and data; the FIFO is the slave.
interface sync_fifo_flagged_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// overflow/underflow pulses; registered-read or first-word-fall-through output.
module sync_fifo_flagged #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 4,
   parameter bit FWFT       = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   sync_fifo_flagged_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]         wr_ptr, rd_ptr, count_q, count_nxt;
   logic                  empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
   logic                  rd_ok, wr_ok;

   // Handshake: a read is taken when rd_en is high and the FIFO is not empty;
   // a write is taken when wr_en is high and the FIFO is not full, or is full
   // but a read is taken on the same edge. A rejected request changes no state
   // and raises overflow/underflow for the following cycle only.
   assign rd_ok = bus.rd_en & ~empty_q;
   assign wr_ok = bus.wr_en & (~full_q | rd_ok);

   always_comb begin
      count_nxt = count_q;
      if (wr_ok && !rd_ok)
         count_nxt = count_q + CW'(1);
      else if (rd_ok && !wr_ok)
         count_nxt = count_q - CW'(1);
   end

   // Flags are registered from the next count so they always agree with count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + CW'(1);
         if (rd_ok)
            rd_ptr <= rd_ptr + CW'(1);
         count_q <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == DEPTH_C);
         af_q    <= (count_nxt >= AF_C);
         ae_q    <= (count_nxt <= AE_C);
         ovf_q   <= bus.wr_en & ~wr_ok;
         unf_q   <= bus.rd_en & empty_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr[AW-1:0]] <= bus.din;
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.dout = mem[rd_ptr[AW-1:0]];
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               dout_q <= '0;
            else if (rd_ok)
               dout_q <= mem[rd_ptr[AW-1:0]];
         end
         assign bus.dout = dout_q;
      end
   endgenerate

   assign bus.count        = count_q;
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: one registered-read instance and one FWFT instance,
// each tracked by a queue-based reference model.
module tb_sync_fifo_flagged;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int AF = 12;
   localparam int AE = 4;

   logic clk = 1'b0;
   logic rst0_n = 1'b0;
   logic rst1_n = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_flagged_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b0 ();
   sync_fifo_flagged_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b1 ();

   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
      dut0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
      dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));

   int n_checks = 0;
   int n_pass = 0;

   // Reference model state: contents as a queue plus the expected pulses.
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   logic [DW-1:0] exp_dout0 = '0;
   bit exp_ovf0, exp_unf0, exp_ovf1, exp_unf1;

   // {full, empty, almost_full, almost_empty, overflow, underflow}
   function automatic logic [5:0] flags_of(int n, bit ovf, bit unf);
      return {n == DEPTH, n == 0, n >= AF, n <= AE, ovf, unf};
   endfunction

   task automatic step0(input bit we, input logic [DW-1:0] d, input bit re);
      bit rd_acc, wr_acc;
      @(negedge clk);
      b0.wr_en = we; b0.din = d; b0.rd_en = re;
      @(posedge clk);
      rd_acc = re && exp_q0.size() != 0;
      wr_acc = we && (exp_q0.size() < DEPTH || rd_acc);
      exp_unf0 = re && exp_q0.size() == 0;
      exp_ovf0 = we && !wr_acc;
      if (rd_acc) exp_dout0 = exp_q0.pop_front();
      if (wr_acc) exp_q0.push_back(d);
      #1;
      b0.wr_en = 1'b0; b0.rd_en = 1'b0;
   endtask

   task automatic step1(input bit we, input logic [DW-1:0] d, input bit re);
      bit rd_acc, wr_acc;
      @(negedge clk);
      b1.wr_en = we; b1.din = d; b1.rd_en = re;
      @(posedge clk);
      rd_acc = re && exp_q1.size() != 0;
      wr_acc = we && (exp_q1.size() < DEPTH || rd_acc);
      exp_unf1 = re && exp_q1.size() == 0;
      exp_ovf1 = we && !wr_acc;
      if (rd_acc) void'(exp_q1.pop_front());
      if (wr_acc) exp_q1.push_back(d);
      #1;
      b1.wr_en = 1'b0; b1.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      b0.wr_en = 0; b0.rd_en = 0; b0.din = '0;
      b1.wr_en = 0; b1.rd_en = 0; b1.din = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow} !== 6'b010100)
         $display("FAIL reset_flags0 got %b exp 010100",
                  {b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow});
      else n_pass++;
      n_checks++;
      if (b0.count !== 5'd0 || b0.dout !== 8'h00)
         $display("FAIL reset_count_dout0 got count=%0d dout=%h exp 0/00", b0.count, b0.dout);
      else n_pass++;
      n_checks++;
      if ({b1.count, b1.empty} !== {5'd0, 1'b1})
         $display("FAIL reset_fwft got count=%0d empty=%b exp 0/1", b1.count, b1.empty);
      else n_pass++;
      @(negedge clk);
      rst0_n = 1'b1; rst1_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         step0(1'b1, 8'(i), 1'b0);
         n_checks++;
         if (b0.count !== 5'(i) || b0.almost_full !== (i >= AF) || b0.full !== (i == DEPTH))
            $display("FAIL fill i=%0d got count=%0d af=%b full=%b exp count=%0d af=%b full=%b",
                     i, b0.count, b0.almost_full, b0.full, i, i >= AF, i == DEPTH);
         else n_pass++;
      end
      step0(1'b1, 8'hAA, 1'b0);
      n_checks++;
      if (b0.overflow !== 1'b1 || b0.count !== 5'd16 || b0.full !== 1'b1)
         $display("FAIL overflow got ovf=%b count=%0d full=%b exp 1/16/1", b0.overflow, b0.count, b0.full);
      else n_pass++;
      step0(1'b0, 8'h00, 1'b0);
      n_checks++;
      if (b0.overflow !== 1'b0)
         $display("FAIL overflow_pulse got %b exp 0", b0.overflow);
      else n_pass++;
   endtask

   task automatic test_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         n_checks++;
         if (b0.dout !== 8'(i) || b0.dout !== exp_dout0)
            $display("FAIL drain_dout i=%0d got %h exp %h", i, b0.dout, 8'(i));
         else n_pass++;
         n_checks++;
         if (b0.almost_empty !== (DEPTH - i <= AE) || b0.empty !== (i == DEPTH))
            $display("FAIL drain_flags i=%0d got ae=%b empty=%b exp ae=%b empty=%b",
                     i, b0.almost_empty, b0.empty, DEPTH - i <= AE, i == DEPTH);
         else n_pass++;
      end
      step0(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (b0.underflow !== 1'b1 || b0.dout !== 8'h10 || b0.count !== 5'd0)
         $display("FAIL underflow got unf=%b dout=%h count=%0d exp 1/10/0", b0.underflow, b0.dout, b0.count);
      else n_pass++;
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < DEPTH; i++) step0(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      step0(1'b1, 8'h55, 1'b1);
      n_checks++;
      if (b0.count !== 5'd16 || b0.full !== 1'b1 || b0.overflow !== 1'b0)
         $display("FAIL full_rw got count=%0d full=%b ovf=%b exp 16/1/0", b0.count, b0.full, b0.overflow);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         n_checks++;
         if (b0.dout !== exp_dout0)
            $display("FAIL full_rw_dout i=%0d got %h exp %h", i, b0.dout, exp_dout0);
         else n_pass++;
      end
      n_checks++;
      if (b0.dout !== 8'h55)
         $display("FAIL full_rw_last got %h exp 55", b0.dout);
      else n_pass++;
   endtask

   task automatic test_empty_rw();
      step0(1'b1, 8'h77, 1'b1);
      n_checks++;
      if (b0.underflow !== 1'b1 || b0.count !== 5'd1 || b0.empty !== 1'b0)
         $display("FAIL empty_rw got unf=%b count=%0d empty=%b exp 1/1/0", b0.underflow, b0.count, b0.empty);
      else n_pass++;
      step0(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (b0.dout !== 8'h77 || b0.count !== 5'd0)
         $display("FAIL empty_rw_read got dout=%h count=%0d exp 77/0", b0.dout, b0.count);
      else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 23; i++) begin
         step0(i < 20, 8'(i), i >= 3);
         n_checks++;
         if (b0.count !== 5'(exp_q0.size()) || (i >= 3 && b0.dout !== 8'(i - 3)))
            $display("FAIL wrap i=%0d got count=%0d dout=%h exp count=%0d dout=%h",
                     i, b0.count, b0.dout, exp_q0.size(), 8'(i - 3));
         else n_pass++;
      end
   endtask

   task automatic test_random0();
      bit we, re;
      for (int i = 0; i < 400; i++) begin
         we = $urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 25);
         re = $urandom_range(0, 99) < ((i % 100) < 50 ? 25 : 75);
         step0(we, 8'($urandom_range(0, 255)), re);
         n_checks++;
         if (b0.count !== 5'(exp_q0.size()))
            $display("FAIL rand0_count i=%0d got %0d exp %0d", i, b0.count, exp_q0.size());
         else n_pass++;
         n_checks++;
         if ({b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow}
             !== flags_of(exp_q0.size(), exp_ovf0, exp_unf0))
            $display("FAIL rand0_flags i=%0d got %b exp %b", i,
                     {b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow},
                     flags_of(exp_q0.size(), exp_ovf0, exp_unf0));
         else n_pass++;
         n_checks++;
         if (b0.dout !== exp_dout0)
            $display("FAIL rand0_dout i=%0d got %h exp %h", i, b0.dout, exp_dout0);
         else n_pass++;
      end
   endtask

   task automatic test_fwft();
      step1(1'b1, 8'hA5, 1'b0);
      n_checks++;
      if (b1.empty !== 1'b0 || b1.dout !== 8'hA5)
         $display("FAIL fwft_show got empty=%b dout=%h exp 0/a5", b1.empty, b1.dout);
      else n_pass++;
      step1(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (b1.empty !== 1'b1 || b1.count !== 5'd0)
         $display("FAIL fwft_pop got empty=%b count=%0d exp 1/0", b1.empty, b1.count);
      else n_pass++;
      for (int i = 0; i < 7; i++) step1(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (b1.count !== 5'd7 || b1.dout !== exp_q1[0])
         $display("FAIL fwft_fill got count=%0d dout=%h exp 7/%h", b1.count, b1.dout, exp_q1[0]);
      else n_pass++;
      #2;
      rst1_n = 1'b0;
      #1;
      n_checks++;
      if (b1.count !== 5'd0 || b1.empty !== 1'b1 || b1.overflow !== 1'b0 || b1.underflow !== 1'b0)
         $display("FAIL fwft_async_reset got count=%0d empty=%b exp 0/1", b1.count, b1.empty);
      else n_pass++;
      exp_q1.delete();
      exp_ovf1 = 0; exp_unf1 = 0;
      @(negedge clk);
      rst1_n = 1'b1;
   endtask

   task automatic test_random1();
      bit we, re;
      for (int i = 0; i < 400; i++) begin
         we = $urandom_range(0, 99) < ((i % 80) < 40 ? 75 : 25);
         re = $urandom_range(0, 99) < ((i % 80) < 40 ? 25 : 75);
         step1(we, 8'($urandom_range(0, 255)), re);
         n_checks++;
         if (b1.count !== 5'(exp_q1.size()) ||
             {b1.full, b1.empty, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow}
             !== flags_of(exp_q1.size(), exp_ovf1, exp_unf1))
            $display("FAIL rand1_state i=%0d got count=%0d flags=%b exp count=%0d flags=%b", i,
                     b1.count, {b1.full, b1.empty, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow},
                     exp_q1.size(), flags_of(exp_q1.size(), exp_ovf1, exp_unf1));
         else n_pass++;
         if (exp_q1.size() != 0) begin
            n_checks++;
            if (b1.dout !== exp_q1[0])
               $display("FAIL rand1_dout i=%0d got %h exp %h", i, b1.dout, exp_q1[0]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_random0();
      test_fwft();
      test_random1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Parametrised next-generation synchronous FIFO with a single clock domain. Adds an occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. Supports simultaneous read/write when full. Has a selectable output mode: registered read or first-word-fall-through (FWFT). It is the drop-in buffer for datapath blocks that need back-pressure earlier than the hard full flag.

Parameters:
DATA_WIDTH, 8, width of din/dout in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read mode, 1 = first-word-fall-through mode

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT: pop the head word)
dout  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Clock and reset: one clock, clk. rst_n is an asynchronous, active-low reset. Assertion takes effect immediately, regardless of clk. Deassertion is sampled at the rising edge of clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - overflow = underflow = 0
  - dout = 0 in registered mode
  - Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits. The address is the low bits; the MSB is a wrap bit. The address wraps DEPTH-1 -> 0 with no bubble.
- Accept rules, evaluated each rising edge:
  - rd_ok = rd_en & !empty
  - wr_ok = wr_en & (!full | rd_ok). A write is accepted when full only if a read is accepted in the same cycle.
  - A read is never accepted when empty, even if a write occurs in the same cycle.
- count update: +1 on wr_ok only; -1 on rd_ok only; unchanged if both or neither.
- Flags: empty, full, almost_full and almost_empty are registered. They are computed from the next count, so on every cycle they agree with the count output.
- Errors:
  - overflow = registered (wr_en & !wr_ok).
  - underflow = registered (rd_en & empty).
  - Each is high for exactly the cycle after the offending request.
  - A rejected access changes no state: pointers, count and memory are untouched.
- Registered mode (FWFT=0):
  - On rd_ok, dout loads mem[rd_addr] at that edge, so data is valid on the cycle after rd_en is sampled (1-cycle read latency).
  - dout holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_addr] combinationally, so it is valid whenever empty = 0.
  - rd_en acknowledges (pops) the current word; the next word appears in the same cycle as the pointer advance.
  - dout is don't-care while empty = 1.
- Write latency: a word written at edge N is readable at edge N+1. In FWFT mode it is visible on dout after edge N, once empty falls.
- Reset mid-operation: all state returns to reset values immediately. Data in flight is discarded; no error pulse is generated.

Test Plan:
1. Reset, FWFT=0: write 0x01..0x10 (16 words) -> count steps 1..16. almost_full rises when count = 12; full rises when count = 16. A 17th write (0xAA) -> overflow pulses 1 cycle; count stays 16.
2. Drain from test 1 with rd_en held for 16 cycles -> dout = 0x01..0x10, each 1 cycle after its read. almost_empty rises when count = 4; empty rises when count = 0. A 17th read -> underflow pulses; dout holds 0x10.
3. Full FIFO, wr_en = rd_en = 1 with din = 0x55 -> count stays 16, full stays 1, no overflow; 0x55 later emerges after the 15 remaining words.
4. Empty FIFO, wr_en = rd_en = 1 with din = 0x77 -> underflow pulses, count = 1; 0x77 is read out on the next rd_en.
5. Wrap test: 20 cycles of interleaved write/read with count oscillating 0..3 -> pointers wrap past 15, and the data order is preserved for values 0x00..0x13.
6. FWFT=1: write 0xA5 -> after one edge empty = 0 and dout = 0xA5 with no rd_en. Then assert rd_en -> empty = 1 next cycle. Assert rst_n = 0 mid-fill at count = 7 -> count = 0 and empty = 1 immediately, without waiting for clk.
